// File: rtl/fb_arb_pkg.sv
// ---------------------------------------------------------------------------
// fb_arb_pkg
// Shared definitions for the framebuffer access arbiter: the arbiter state
// encoding, framebuffer port widths, timeout counter width, and a saturating
// increment helper for that counter.
// ---------------------------------------------------------------------------
package fb_arb_pkg;

  localparam int FB_ADDR_W = 24;
  localparam int FB_DATA_W = 16;
  localparam int FB_MASK_W = 4;
  localparam int TMO_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  // Counter sticks at all-ones instead of wrapping.
  function automatic logic [TMO_CNT_W-1:0] sat_inc(input logic [TMO_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fb_rr_pick.sv
// ---------------------------------------------------------------------------
// fb_rr_pick
// Combinational round-robin picker. The search starts at last_grant+1 and
// wraps modulo NUM_REQ, so the previous owner has the lowest priority.
//   req        : request vector, one bit per requester
//   last_grant : index of the previous owner
//   valid      : at least one request is set
//   winner     : index of the chosen requester (0 when valid is low)
// ---------------------------------------------------------------------------
module fb_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               valid,
  output logic [IDX_W-1:0]   winner
);

  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    valid    = 1'b0;
    winner   = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand     = (int'(last_grant) + i) % NUM_REQ;
      cand_idx = cand[IDX_W-1:0];
      if (!valid && req[cand_idx]) begin
        valid  = 1'b1;
        winner = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fb_access_arbiter.sv
// ---------------------------------------------------------------------------
// fb_access_arbiter
// Round-robin arbiter that multiplexes NUM_REQ requesters onto a single
// framebuffer access port. One access is in flight at a time:
// IDLE -> BUSY (access issued) -> DONE (one dead cycle) -> IDLE.
//   clk_pix, reset_i       : clock, async active-high reset
//   req_sel_i / req_wr_i   : per-requester request and write/read select
//   req_mask_i / req_address_i / req_data_i : per-requester access fields
//   req_ack_o / req_data_o : one-cycle completion pulse and shared read data
//   fb_*_o, fb_ack_i, fb_data_i : framebuffer access port
//   grant_o                : current or last owner
//   busy_o                 : high in BUSY or DONE
//   err_timeout_o          : sticky flag, access stuck in BUSY too long
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module fb_access_arbiter
  import fb_arb_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                clk_pix,
  input  logic                                reset_i,
  input  logic [NUM_REQ-1:0]                  req_sel_i,
  input  logic [NUM_REQ-1:0]                  req_wr_i,
  input  logic [NUM_REQ-1:0][FB_MASK_W-1:0]   req_mask_i,
  input  logic [NUM_REQ-1:0][FB_ADDR_W-1:0]   req_address_i,
  input  logic [NUM_REQ-1:0][FB_DATA_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]                  req_ack_o,
  output logic [FB_DATA_W-1:0]                req_data_o,
  output logic                                fb_sel_o,
  output logic                                fb_wr_o,
  output logic [FB_MASK_W-1:0]                fb_mask_o,
  output logic [FB_ADDR_W-1:0]                fb_address_o,
  output logic [FB_DATA_W-1:0]                fb_data_o,
  input  logic                                fb_ack_i,
  input  logic [FB_DATA_W-1:0]                fb_data_i,
  output logic [$clog2(NUM_REQ)-1:0]          grant_o,
  output logic                                busy_o,
  output logic                                err_timeout_o
);

  localparam int                     IDX_W    = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [TMO_CNT_W-1:0]   TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e             state;
  arb_state_e             state_nxt;
  logic [IDX_W-1:0]       last_grant;
  logic [TMO_CNT_W-1:0]   tmo_cnt;
  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;

  fb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req_sel_i),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_idx)
  );

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_pix or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_valid) state_nxt = BUSY;
      BUSY:    if (fb_ack_i)   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_pix or posedge reset_i) begin
    if (reset_i) begin
      fb_sel_o      <= 1'b0;
      fb_wr_o       <= 1'b0;
      fb_mask_o     <= '0;
      fb_address_o  <= '0;
      fb_data_o     <= '0;
      req_ack_o     <= '0;
      req_data_o    <= '0;
      grant_o       <= '0;
      last_grant    <= LAST_IDX;  // requester 0 wins the first arbitration
      busy_o        <= 1'b0;
      err_timeout_o <= 1'b0;
      tmo_cnt       <= '0;
    end else begin
      req_ack_o <= '0;  // pulse: only the completing edge sets a bit
      busy_o    <= (state_nxt != IDLE);
      unique case (state)
        IDLE: begin
          // Winner's fields are captured once; the port stays frozen until
          // the access completes, whatever the requester does meanwhile.
          if (pick_valid) begin
            fb_sel_o     <= 1'b1;
            fb_wr_o      <= req_wr_i[pick_idx];
            fb_mask_o    <= req_mask_i[pick_idx];
            fb_address_o <= req_address_i[pick_idx];
            fb_data_o    <= req_data_i[pick_idx];
            grant_o      <= pick_idx;
          end
        end
        BUSY: begin
          if (fb_ack_i) begin
            fb_sel_o           <= 1'b0;
            req_ack_o[grant_o] <= 1'b1;
            if (!fb_wr_o) req_data_o <= fb_data_i;
            last_grant         <= grant_o;
            tmo_cnt            <= '0;
          end else begin
            // Timeout only flags; the access keeps waiting for its ack.
            tmo_cnt <= sat_inc(tmo_cnt);
            if (tmo_cnt == TMO_LAST) err_timeout_o <= 1'b1;
          end
        end
        default: ;  // DONE: acks in IDLE/DONE are ignored
      endcase
    end
  end

endmodule

// File: tb/tb_fb_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fb_access_arbiter
// Directed bench for fb_access_arbiter (NUM_REQ=3, TIMEOUT_CYCLES=8).
// Expected completions (requester index, req_data_o) are queued as each
// access is set up; a negedge monitor pops and compares every req_ack_o pulse.
// ---------------------------------------------------------------------------
module tb_fb_access_arbiter;
  import fb_arb_pkg::*;

  localparam int NUM_REQ = 3;
  localparam int IDX_W   = $clog2(NUM_REQ);

  logic                              clk_pix = 1'b0;
  logic                              reset_i;
  logic [NUM_REQ-1:0]                req_sel_i;
  logic [NUM_REQ-1:0]                req_wr_i;
  logic [NUM_REQ-1:0][FB_MASK_W-1:0] req_mask_i;
  logic [NUM_REQ-1:0][FB_ADDR_W-1:0] req_address_i;
  logic [NUM_REQ-1:0][FB_DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]                req_ack_o;
  logic [FB_DATA_W-1:0]              req_data_o;
  logic                              fb_sel_o;
  logic                              fb_wr_o;
  logic [FB_MASK_W-1:0]              fb_mask_o;
  logic [FB_ADDR_W-1:0]              fb_address_o;
  logic [FB_DATA_W-1:0]              fb_data_o;
  logic                              fb_ack_i;
  logic [FB_DATA_W-1:0]              fb_data_i;
  logic [IDX_W-1:0]                  grant_o;
  logic                              busy_o;
  logic                              err_timeout_o;

  typedef struct {
    int          idx;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  fb_access_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_pix       (clk_pix),
    .reset_i       (reset_i),
    .req_sel_i     (req_sel_i),
    .req_wr_i      (req_wr_i),
    .req_mask_i    (req_mask_i),
    .req_address_i (req_address_i),
    .req_data_i    (req_data_i),
    .req_ack_o     (req_ack_o),
    .req_data_o    (req_data_o),
    .fb_sel_o      (fb_sel_o),
    .fb_wr_o       (fb_wr_o),
    .fb_mask_o     (fb_mask_o),
    .fb_address_o  (fb_address_o),
    .fb_data_o     (fb_data_o),
    .fb_ack_i      (fb_ack_i),
    .fb_data_i     (fb_data_i),
    .grant_o       (grant_o),
    .busy_o        (busy_o),
    .err_timeout_o (err_timeout_o)
  );

  always #5 clk_pix = ~clk_pix;
  always @(posedge clk_pix) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_pix);
    #1;
  endtask

  task automatic wait_sel(input string tag);
    int n = 0;
    while (fb_sel_o !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    check({tag, "_sel_seen"}, 32'(fb_sel_o), 1);
  endtask

  task automatic ack_once(input logic [15:0] d);
    fb_data_i = d;
    fb_ack_i  = 1'b1;
    tick(1);
    fb_ack_i  = 1'b0;
  endtask

  // Scoreboard: every req_ack_o pulse must match the oldest queued access.
  always @(negedge clk_pix) begin
    if (req_ack_o !== '0) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'(req_ack_o), 0);
      end else begin
        mon_e = sb.pop_front();
        check("ack_vec", 32'(req_ack_o), 1 << mon_e.idx);
        check("ack_data", 32'(req_data_o), 32'(mon_e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int prev;
    int last_cyc;
    reset_i       = 1'b1;
    req_sel_i     = '0;
    req_wr_i      = '0;
    req_mask_i    = '0;
    req_address_i = '0;
    req_data_i    = '0;
    fb_ack_i      = 1'b0;
    fb_data_i     = '0;
    #1;
    check("rst_fb_sel", 32'(fb_sel_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_grant", 32'(grant_o), 0);
    check("rst_ack", 32'(req_ack_o), 0);
    check("rst_err", 32'(err_timeout_o), 0);
    check("rst_addr", 32'(fb_address_o), 0);
    check("rst_rdata", 32'(req_data_o), 0);
    tick(2);
    reset_i = 1'b0;

    // Requester 1 write, ack two cycles after fb_sel_o.
    req_sel_i        = 3'b010;
    req_wr_i[1]      = 1'b1;
    req_address_i[1] = 24'h000010;
    req_data_i[1]    = 16'hABCD;
    req_mask_i[1]    = 4'hF;
    sb.push_back('{1, 16'h0000});
    tick(1);
    check("s1_sel", 32'(fb_sel_o), 1);
    check("s1_addr", 32'(fb_address_o), 32'h10);
    check("s1_wdata", 32'(fb_data_o), 32'hABCD);
    check("s1_mask", 32'(fb_mask_o), 32'hF);
    check("s1_wr", 32'(fb_wr_o), 1);
    check("s1_grant", 32'(grant_o), 1);
    check("s1_busy", 32'(busy_o), 1);
    tick(1);
    ack_once(16'h0000);
    check("s1_ack", 32'(req_ack_o), 32'b010);
    check("s1_sel_drop", 32'(fb_sel_o), 0);
    req_sel_i = '0;
    tick(1);
    check("s1_ack_one_cycle", 32'(req_ack_o), 0);
    check("s1_idle", 32'(busy_o), 0);

    // Requester 2 read returns 0x5A5A.
    req_sel_i        = 3'b100;
    req_wr_i[2]      = 1'b0;
    req_address_i[2] = 24'h001234;
    sb.push_back('{2, 16'h5A5A});
    tick(1);
    check("s3_grant", 32'(grant_o), 2);
    check("s3_addr", 32'(fb_address_o), 32'h1234);
    check("s3_wr", 32'(fb_wr_o), 0);
    ack_once(16'h5A5A);
    check("s3_ack", 32'(req_ack_o), 32'b100);
    check("s3_rdata", 32'(req_data_o), 32'h5A5A);
    req_sel_i = '0;
    tick(1);

    // Requester 0 changes its fields mid-access; write keeps req_data_o.
    req_sel_i        = 3'b001;
    req_wr_i[0]      = 1'b1;
    req_address_i[0] = 24'h000010;
    req_data_i[0]    = 16'h1111;
    req_mask_i[0]    = 4'h3;
    sb.push_back('{0, 16'h5A5A});
    tick(1);
    check("s4_addr", 32'(fb_address_o), 32'h10);
    req_address_i[0] = 24'h000020;
    req_data_i[0]    = 16'h2222;
    req_mask_i[0]    = 4'hC;
    tick(2);
    check("s4_addr_frozen", 32'(fb_address_o), 32'h10);
    check("s4_data_frozen", 32'(fb_data_o), 32'h1111);
    check("s4_mask_frozen", 32'(fb_mask_o), 32'h3);
    ack_once(16'hDEAD);
    check("s4_write_keeps_rdata", 32'(req_data_o), 32'h5A5A);
    req_sel_i = '0;
    tick(1);
    // Stray ack while IDLE.
    fb_ack_i = 1'b1;
    tick(1);
    check("stray_ack_none", 32'(req_ack_o), 0);
    fb_ack_i = 1'b0;
    tick(1);
    check("stray_ack_none_late", 32'(req_ack_o), 0);
    check("stray_busy", 32'(busy_o), 0);

    // All three held after reset: order 0,1,2,0,1,2.
    reset_i = 1'b1;
    tick(1);
    reset_i   = 1'b0;
    req_sel_i = 3'b111;
    req_wr_i  = 3'b111;
    prev      = -1;
    for (int k = 0; k < 6; k++) begin
      sb.push_back('{k % 3, 16'h0000});
      wait_sel("rr");
      check("rr_grant", 32'(grant_o), k % 3);
      check("rr_no_repeat", 32'(int'(grant_o) != prev), 1);
      prev = int'(grant_o);
      ack_once(16'h0000);
    end
    req_sel_i = '0;
    tick(1);

    // Single requester held: one grant every 3 cycles with 1-cycle ack.
    req_sel_i = 3'b010;
    last_cyc  = 0;
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{1, 16'h0000});
      wait_sel("rate");
      check("rate_grant", 32'(grant_o), 1);
      if (k > 0) check("rate_period", 32'(cyc - last_cyc), 3);
      last_cyc = cyc;
      ack_once(16'h0000);
    end
    req_sel_i = '0;
    tick(1);

    // Reset two cycles into BUSY, then requester 0 wins first.
    req_sel_i   = 3'b100;
    req_wr_i[2] = 1'b0;
    wait_sel("mid");
    check("mid_grant", 32'(grant_o), 2);
    tick(1);
    reset_i = 1'b1;
    #1;
    check("mid_rst_sel", 32'(fb_sel_o), 0);
    check("mid_rst_busy", 32'(busy_o), 0);
    check("mid_rst_grant", 32'(grant_o), 0);
    req_sel_i = 3'b111;
    tick(1);
    reset_i = 1'b0;
    sb.push_back('{0, 16'h0000});
    wait_sel("post_rst");
    check("post_rst_grant", 32'(grant_o), 0);
    ack_once(16'h0000);
    req_sel_i = '0;
    tick(1);

    // Timeout: no ack for 8 BUSY cycles, then a late ack completes.
    req_sel_i        = 3'b010;
    req_wr_i[1]      = 1'b0;
    req_address_i[1] = 24'h000040;
    wait_sel("tmo");
    tick(7);
    check("tmo_not_yet", 32'(err_timeout_o), 0);
    tick(1);
    check("tmo_set", 32'(err_timeout_o), 1);
    check("tmo_sel_held", 32'(fb_sel_o), 1);
    check("tmo_busy", 32'(busy_o), 1);
    tick(3);
    sb.push_back('{1, 16'hBEEF});
    ack_once(16'hBEEF);
    req_sel_i = '0;
    check("tmo_late_ack", 32'(req_ack_o), 32'b010);
    check("tmo_sticky", 32'(err_timeout_o), 1);
    tick(2);
    check("tmo_sticky_idle", 32'(err_timeout_o), 1);
    check("tmo_idle", 32'(busy_o), 0);

    tick(2);
    check("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
